// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receiver: FSM states, channel codes and
// synchronizer depth.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_sync.sv
// Multi-bit flop-chain synchronizer with synchronous active-low reset.
// Each bit is an independent single-bit crossing.
module i2s_sync
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrclk/sdin in the clk domain and emits one
// parallel word per channel slot with a single-cycle valid strobe.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_sdin,
    output logic [DATA_WIDTH-1:0] i2s_data_out,
    output logic                  i2s_data_valid,
    output logic                  i2s_data_ch,
    output logic                  frame_err
);

    localparam int unsigned       CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [2:0] sync_q;
    logic       bclk_s, lrclk_s, sdin_s;
    logic       bclk_prev, lr_prev;
    logic       bclk_rise, ws_edge;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [DATA_WIDTH-2:0] shreg, shreg_n;
    logic                  ch, ch_n;
    logic                  done, err;

    i2s_sync #(
        .WIDTH (3),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .resetn(resetn),
        .d     ({i2s_bclk, i2s_lrclk, i2s_sdin}),
        .q     (sync_q)
    );

    assign bclk_s  = sync_q[2];
    assign lrclk_s = sync_q[1];
    assign sdin_s  = sync_q[0];

    assign bclk_rise = bclk_s & ~bclk_prev;
    assign ws_edge   = bclk_rise & (lrclk_s ^ lr_prev);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bclk_prev <= 1'b0;
            lr_prev   <= 1'b0;
        end else begin
            bclk_prev <= bclk_s;
            if (bclk_rise) begin
                lr_prev <= lrclk_s;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        ch_n    = ch;
        done    = 1'b0;
        err     = 1'b0;
        if (bclk_rise) begin
            case (state)
                IDLE, HOLD: begin
                    if (ws_edge) begin
                        state_n = SHIFT;
                        ch_n    = lrclk_s ? CH_RIGHT : CH_LEFT;
                        cnt_n   = '0;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST_BIT) begin
                        // Completing bit may coincide with the next slot's ws_edge.
                        done    = 1'b1;
                        state_n = ws_edge ? SHIFT : HOLD;
                        if (ws_edge) begin
                            ch_n  = lrclk_s ? CH_RIGHT : CH_LEFT;
                            cnt_n = '0;
                        end
                    end else if (ws_edge) begin
                        err     = 1'b1;
                        state_n = SHIFT;
                        ch_n    = lrclk_s ? CH_RIGHT : CH_LEFT;
                        cnt_n   = '0;
                    end else begin
                        shreg_n = {shreg[DATA_WIDTH-3:0], sdin_s};
                        cnt_n   = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= '0;
            shreg          <= '0;
            ch             <= CH_LEFT;
            i2s_data_out   <= '0;
            i2s_data_valid <= 1'b0;
            i2s_data_ch    <= CH_LEFT;
            frame_err      <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            shreg          <= shreg_n;
            ch             <= ch_n;
            i2s_data_valid <= done;
            if (done) begin
                i2s_data_out <= {shreg, sdin_s};
                i2s_data_ch  <= ch;
            end
            if (err) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames (one-bit delayed data) and
// compares captured words, channels, latency and frame_err against tables.
module tb_i2s_rx;

    localparam int unsigned DW = 24;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          bclk   = 1'b0;
    logic          lrclk  = 1'b0;
    logic          sdin   = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid, ch, ferr;

    int   checks    = 0;
    int   errors    = 0;
    int   half      = 4;
    int   cyc       = 0;
    int   rise_cyc  = 0;
    bit   lat_chk   = 1'b0;
    logic pending   = 1'b0;

    logic [DW:0]   got_q[$];
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] prev_data = '0;
    logic          prev_ch    = 1'b0;
    logic          prev_valid = 1'b0;
    logic          prev_rst   = 1'b0;

    i2s_rx #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i2s_bclk      (bclk),
        .i2s_lrclk     (lrclk),
        .i2s_sdin      (sdin),
        .i2s_data_out  (data_out),
        .i2s_data_valid(valid),
        .i2s_data_ch   (ch),
        .frame_err     (ferr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records words, checks pulse width, latency and hold.
    always @(negedge clk) begin
        if (resetn && prev_rst) begin
            if (valid) begin
                got_q.push_back({ch, data_out});
                check_eq("valid_width", {31'd0, prev_valid}, 32'd0);
                if (lat_chk)
                    check_eq("latency_3_4", {31'd0, ((cyc - rise_cyc) >= 3) && ((cyc - rise_cyc) <= 4)}, 32'd1);
            end else begin
                check_eq("hold_data", {8'd0, data_out}, {8'd0, prev_data});
                check_eq("hold_ch", {31'd0, ch}, {31'd0, prev_ch});
            end
        end
        prev_data  = data_out;
        prev_ch    = ch;
        prev_valid = valid;
        prev_rst   = resetn;
    end

    task automatic bit_period(input logic lr, input logic d);
        lrclk = lr;
        sdin  = d;
        bclk  = 1'b0;
        repeat (half) @(negedge clk);
        bclk     = 1'b1;
        rise_cyc = cyc;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_slot(input logic c, input logic [DW-1:0] w, input int len,
                             input int from, input int to);
        logic cur;
        for (int j = from; j < to; j++) begin
            cur = (j < int'(DW)) ? w[DW-1-j] : 1'b0;
            bit_period(c, pending);
            pending = cur;
        end
    endtask

    task automatic slot(input logic c, input logic [DW-1:0] w, input int len);
        send_slot(c, w, len, 0, len);
    endtask

    task automatic idle(input logic lr, input int n);
        for (int i = 0; i < n; i++) begin
            bit_period(lr, pending);
            pending = 1'b0;
        end
    endtask

    task automatic expect_word(input logic c, input logic [DW-1:0] w);
        exp_q.push_back({c, w});
    endtask

    task automatic finish_scn(input string tag);
        repeat (10) @(negedge clk);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check_eq({tag, "_word"}, {7'd0, got_q[i]}, {7'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        bclk    = 1'b0;
        lrclk   = 1'b0;
        sdin    = 1'b0;
        pending = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outs_zero(input string tag);
        check_eq({tag, "_data"}, {8'd0, data_out}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check_eq({tag, "_ch"}, {31'd0, ch}, 32'd0);
        check_eq({tag, "_ferr"}, {31'd0, ferr}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] w;
        logic          c;
        int            len;

        @(negedge clk);
        repeat (4) @(negedge clk);
        check_outs_zero("reset");

        // Nominal 32-bit slots, clk/bclk = 8
        do_reset();
        lat_chk = 1'b1;
        idle(1'b0, 3);
        slot(1'b1, 24'h123456, 32); expect_word(1'b1, 24'h123456);
        slot(1'b0, 24'hABCDEF, 32); expect_word(1'b0, 24'hABCDEF);
        slot(1'b1, 24'h123456, 32); expect_word(1'b1, 24'h123456);
        slot(1'b0, 24'hABCDEF, 32); expect_word(1'b0, 24'hABCDEF);
        idle(1'b0, 2);
        finish_scn("nominal");
        check_eq("nominal_ferr", {31'd0, ferr}, 32'd0);

        // Exact-width 24-bit slots: completion coincides with ws_edge
        do_reset();
        idle(1'b0, 3);
        slot(1'b1, 24'h800000, 24); expect_word(1'b1, 24'h800000);
        slot(1'b0, 24'h7FFFFF, 24); expect_word(1'b0, 24'h7FFFFF);
        slot(1'b1, 24'h800000, 24); expect_word(1'b1, 24'h800000);
        slot(1'b0, 24'h7FFFFF, 24); expect_word(1'b0, 24'h7FFFFF);
        idle(1'b1, 2);
        finish_scn("exact");
        check_eq("exact_ferr", {31'd0, ferr}, 32'd0);

        // Short 16-bit slot
        do_reset();
        idle(1'b0, 3);
        slot(1'b1, 24'h123456, 32); expect_word(1'b1, 24'h123456);
        check_eq("short_ferr_before", {31'd0, ferr}, 32'd0);
        slot(1'b0, 24'hABCDEF, 16);
        slot(1'b1, 24'h654321, 32); expect_word(1'b1, 24'h654321);
        check_eq("short_ferr_set", {31'd0, ferr}, 32'd1);
        slot(1'b0, 24'h0F0F0F, 32); expect_word(1'b0, 24'h0F0F0F);
        idle(1'b0, 2);
        finish_scn("short");
        check_eq("short_ferr_sticky", {31'd0, ferr}, 32'd1);

        // Reset released mid-way through a left slot
        resetn  = 1'b0;
        pending = 1'b0;
        send_slot(1'b0, 24'h111111, 32, 0, 10);
        resetn = 1'b1;
        send_slot(1'b0, 24'h111111, 32, 10, 32);
        slot(1'b1, 24'h222222, 32); expect_word(1'b1, 24'h222222);
        slot(1'b0, 24'h333333, 32); expect_word(1'b0, 24'h333333);
        idle(1'b1, 2);
        finish_scn("startup");
        check_eq("startup_ferr", {31'd0, ferr}, 32'd0);

        // Reset pulsed for 2 clk while shifting
        do_reset();
        idle(1'b0, 3);
        slot(1'b1, 24'h123456, 32); expect_word(1'b1, 24'h123456);
        send_slot(1'b0, 24'hABCDEF, 32, 0, 10);
        check_eq("midrst_pre_data", {8'd0, data_out}, 32'h123456);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_outs_zero("midrst");
        resetn = 1'b1;
        send_slot(1'b0, 24'hABCDEF, 32, 10, 32);
        slot(1'b1, 24'h456789, 32); expect_word(1'b1, 24'h456789);
        slot(1'b0, 24'h9ABCDE, 32); expect_word(1'b0, 24'h9ABCDE);
        idle(1'b1, 2);
        finish_scn("midrst");
        check_eq("midrst_ferr", {31'd0, ferr}, 32'd0);

        // Minimum oversampling, clk/bclk = 4, random words
        do_reset();
        half    = 2;
        lat_chk = 1'b0;
        idle(1'b0, 3);
        for (int k = 0; k < 8; k++) begin
            c   = (k % 2 == 0) ? 1'b1 : 1'b0;
            w   = DW'($urandom);
            len = (k % 3 == 0) ? 24 : 32;
            slot(c, w, len);
            expect_word(c, w);
        end
        idle(1'b1, 2);
        finish_scn("minos");
        check_eq("minos_ferr", {31'd0, ferr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
